// File: rtl/ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger.
//   ranger_state_e : measurement FSM states
//   DIST_W         : width of the reported distance
//   DIST_INVALID   : distance code for "no echo" or "overrange"
//   cnt_width()    : bits needed for a counter running 0..max_val-1
package ranger_pkg;

    localparam int DIST_W = 20;
    localparam logic [DIST_W-1:0] DIST_INVALID = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        MEAS,
        DRAIN
    } ranger_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler. Free-running from reset; counts 0..CLK_DIV-1
// and asserts tick for one clk while the count sits at CLK_DIV-1.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   tick  : one-clk pulse per microsecond
module us_tick_gen
    import ranger_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = cnt_width(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == PRE_LAST);

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ultrasonic ranger. Fires a trigger pulse once per measurement
// period, times the echo pulse in microseconds and converts it to whole
// centimeters while the echo is still high.
//   clk            : system clock
//   reset          : asynchronous active-low reset
//   echo           : sensor echo pin (asynchronous, synchronized here)
//   trig           : sensor trigger pin
//   distance_data  : last distance in cm, DIST_INVALID for no echo/overrange
//   data_valid     : one-clk pulse when distance_data is updated
//   out_of_range   : high while distance_data holds DIST_INVALID
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for the period wrap tick to start a measurement
// TRIG  | trig high for TRIG_US ticks
// WAIT  | waiting for echo rise, bounded by ECHO_WAIT_US ticks
// MEAS  | echo high; counting sub-cm ticks and whole centimeters
// DRAIN | overrange reported; waiting for the echo to end
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int CLK_DIV      = 50,
    parameter int TRIG_US      = 10,
    parameter int CM_US        = 58,
    parameter int ECHO_WAIT_US = 5000,
    parameter int MAX_CM       = 400,
    parameter int CYCLE_US     = 60000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance_data,
    output logic              data_valid,
    output logic              out_of_range
);

    localparam int US_MAX = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
    localparam int US_W   = cnt_width(US_MAX);
    localparam int PER_W  = cnt_width(CYCLE_US);
    localparam int SUB_W  = cnt_width(CM_US);

    localparam logic [US_W-1:0]   TRIG_LAST = US_W'(TRIG_US - 1);
    localparam logic [US_W-1:0]   WAIT_LAST = US_W'(ECHO_WAIT_US - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(CYCLE_US - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CM_US - 1);
    localparam logic [DIST_W-1:0] CM_LIMIT  = DIST_W'(MAX_CM);

    logic tick;

    us_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    logic echo_meta_q, echo_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    // Period counter runs independently of the FSM so the trigger cadence
    // never drifts with echo timing.
    logic [PER_W-1:0] per_q, per_d;

    always_comb begin
        per_d = per_q;
        if (tick) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        end
    end

    ranger_state_e     state_q, state_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [SUB_W-1:0]  sub_q, sub_d, sub_step;
    logic [DIST_W-1:0] cm_q, cm_d, cm_step;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              oor_q, oor_d;
    logic              valid_q, valid_d;
    logic              trig_q, trig_d;

    // Counters as they would be after this cycle's tick. The result taken on
    // echo fall includes that final tick, so an N us echo counts N ticks.
    always_comb begin
        sub_step = sub_q;
        cm_step  = cm_q;
        if (tick) begin
            if (sub_q == SUB_LAST) begin
                sub_step = '0;
                cm_step  = cm_q + 1'b1;
            end else begin
                sub_step = sub_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        us_d    = us_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        oor_d   = oor_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && (per_q == PER_LAST) && !echo_s_q) begin
                    state_d = TRIG;
                    us_d    = '0;
                end
            end
            TRIG: begin
                if (tick) begin
                    if (us_q == TRIG_LAST) begin
                        state_d = WAIT;
                        us_d    = '0;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                // Echo rise is checked first so it beats a same-cycle timeout.
                if (echo_s_q) begin
                    state_d = MEAS;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (tick) begin
                    if (us_q == WAIT_LAST) begin
                        dist_d  = DIST_INVALID;
                        oor_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        us_d = us_q + 1'b1;
                    end
                end
            end
            MEAS: begin
                // Echo fall is checked first so it beats a same-cycle limit.
                if (!echo_s_q) begin
                    dist_d  = cm_step;
                    oor_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (cm_step == CM_LIMIT) begin
                    dist_d  = DIST_INVALID;
                    oor_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    sub_d = sub_step;
                    cm_d  = cm_step;
                end
            end
            DRAIN: begin
                if (!echo_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        trig_d = (state_d == TRIG);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            per_q   <= '0;
            us_q    <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            oor_q   <= 1'b0;
            valid_q <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            us_q    <= us_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            oor_q   <= oor_d;
            valid_q <= valid_d;
            trig_q  <= trig_d;
        end
    end

    assign trig          = trig_q;
    assign distance_data = dist_q;
    assign data_valid    = valid_q;
    assign out_of_range  = oor_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger using a small parameter set.
module tb_ultrasonic_ranger;

    localparam int CLK_DIV      = 2;
    localparam int TRIG_US      = 10;
    localparam int CM_US        = 58;
    localparam int ECHO_WAIT_US = 500;
    localparam int MAX_CM       = 20;
    localparam int CYCLE_US     = 2000;
    localparam int PERIOD_CLK   = CYCLE_US * CLK_DIV;
    localparam logic [19:0] INVALID = 20'hFFFFF;

    logic        clk;
    logic        reset;
    logic        echo;
    logic        trig;
    logic [19:0] distance_data;
    logic        data_valid;
    logic        out_of_range;

    int n_tests;
    int n_fail;
    int cyc;

    int          vq_cyc[$];
    logic [19:0] vq_dist[$];
    logic        vq_oor[$];

    ultrasonic_ranger #(
        .CLK_DIV     (CLK_DIV),
        .TRIG_US     (TRIG_US),
        .CM_US       (CM_US),
        .ECHO_WAIT_US(ECHO_WAIT_US),
        .MAX_CM      (MAX_CM),
        .CYCLE_US    (CYCLE_US)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .echo         (echo),
        .trig         (trig),
        .distance_data(distance_data),
        .data_valid   (data_valid),
        .out_of_range (out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset && data_valid) begin
            vq_cyc.push_back(cyc);
            vq_dist.push_back(distance_data);
            vq_oor.push_back(out_of_range);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: an echo of us microseconds is us ticks; floor to cm,
    // invalid once the count passes MAX_CM centimeters.
    function automatic logic [19:0] exp_dist(input int us);
        if (us > MAX_CM * CM_US) return INVALID;
        return 20'(us / CM_US);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_vq();
        vq_cyc.delete();
        vq_dist.delete();
        vq_oor.delete();
    endtask

    task automatic wait_trig(output int rise_c, output int fall_c, output bit ok);
        int n;
        rise_c = -1;
        fall_c = -1;
        ok = 1'b0;
        n = 0;
        while (trig !== 1'b1 && n < 2 * PERIOD_CLK + 100) begin
            step();
            n++;
        end
        if (trig === 1'b1) begin
            rise_c = cyc;
            n = 0;
            while (trig !== 1'b0 && n < 100) begin
                step();
                n++;
            end
            if (trig === 1'b0) begin
                fall_c = cyc;
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_valid(input int need, input int bound);
        int n;
        n = 0;
        while (vq_cyc.size() < need && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic run_echo(input int delay_us, input int len_us, input bit clr,
                            output int fall_c, output bit ok);
        int r, f;
        fall_c = -1;
        wait_trig(r, f, ok);
        if (!ok) return;
        if (clr) clear_vq();
        repeat (delay_us * CLK_DIV) step();
        echo = 1'b1;
        repeat (len_us * CLK_DIV) step();
        echo = 1'b0;
        fall_c = cyc;
    endtask

    task automatic test_reset();
        int r, f;
        bit ok;
        reset = 1'b0;
        echo  = 1'b0;
        step();
        step();
        n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b expected 0", trig); end
        n_tests++; if (distance_data !== 20'h0) begin n_fail++; $display("FAIL reset_dist: got %0h expected 0", distance_data); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_tests++; if (out_of_range !== 1'b0) begin n_fail++; $display("FAIL reset_oor: got %b expected 0", out_of_range); end
        reset = 1'b1;
        wait_trig(r, f, ok);
        clear_vq();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL first_trig_seen: got none expected trigger"); end
        n_tests++; if (r != PERIOD_CLK) begin n_fail++; $display("FAIL first_trig_cycle: got %0d expected %0d", r, PERIOD_CLK); end
        n_tests++; if (f - r != TRIG_US * CLK_DIV) begin n_fail++; $display("FAIL trig_width: got %0d expected %0d", f - r, TRIG_US * CLK_DIV); end
        wait_valid(1, ECHO_WAIT_US * CLK_DIV + 50);
        repeat (20) step();
        n_tests++;
        if (vq_cyc.size() != 1) begin
            n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", vq_cyc.size());
        end else begin
            n_tests++; if (vq_cyc[0] != f + ECHO_WAIT_US * CLK_DIV) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", vq_cyc[0], f + ECHO_WAIT_US * CLK_DIV); end
            n_tests++; if (vq_dist[0] !== INVALID) begin n_fail++; $display("FAIL timeout_dist: got %0h expected %0h", vq_dist[0], INVALID); end
            n_tests++; if (vq_oor[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_oor: got %b expected 1", vq_oor[0]); end
        end
    endtask

    task automatic test_echo_lengths();
        int lens[5];
        int fc, d;
        bit ok;
        logic [19:0] e;
        lens[0] = 580;
        lens[1] = 57;
        lens[2] = 1159;
        lens[3] = $urandom_range(1150, 1);
        lens[4] = $urandom_range(1150, 1);
        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(300, 5);
            run_echo(d, lens[i], 1'b1, fc, ok);
            e = exp_dist(lens[i]);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL echo_trig_%0d: got none expected trigger", i); end
            wait_valid(1, 20);
            n_tests++;
            if (vq_cyc.size() == 0) begin
                n_fail++; $display("FAIL echo_valid_%0d: got no pulse expected one (len %0d us)", i, lens[i]);
            end else begin
                n_tests++; if (vq_cyc[0] != fc + 3) begin n_fail++; $display("FAIL echo_latency_%0d: got %0d expected %0d", i, vq_cyc[0], fc + 3); end
                n_tests++; if (vq_dist[0] !== e) begin n_fail++; $display("FAIL echo_dist_%0d: got %0d expected %0d (len %0d us)", i, vq_dist[0], e, lens[i]); end
                n_tests++; if (vq_oor[0] !== 1'b0) begin n_fail++; $display("FAIL echo_oor_%0d: got %b expected 0", i, vq_oor[0]); end
            end
            repeat (10) step();
            n_tests++; if (distance_data !== e) begin n_fail++; $display("FAIL echo_hold_%0d: got %0d expected %0d", i, distance_data, e); end
            n_tests++; if (vq_cyc.size() != 1) begin n_fail++; $display("FAIL echo_pulses_%0d: got %0d expected 1", i, vq_cyc.size()); end
        end
    endtask

    task automatic test_overrange_drain();
        int r, f, r2, f2, c, trig_hi, exp_c;
        bit ok;
        wait_trig(r, f, ok);
        clear_vq();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_trig: got none expected trigger"); end
        repeat (100 * CLK_DIV) step();
        echo = 1'b1;
        c = cyc;
        trig_hi = 0;
        for (int i = 0; i < 2000 * CLK_DIV; i++) begin
            step();
            if (trig === 1'b1) trig_hi++;
        end
        n_tests++; if (out_of_range !== 1'b1) begin n_fail++; $display("FAIL ovr_oor_held: got %b expected 1", out_of_range); end
        echo = 1'b0;
        n_tests++; if (trig_hi != 0) begin n_fail++; $display("FAIL ovr_skip: got %0d trig cycles expected 0", trig_hi); end
        repeat (10) step();
        exp_c = c + 3 + MAX_CM * CM_US * CLK_DIV;
        n_tests++;
        if (vq_cyc.size() != 1) begin
            n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", vq_cyc.size());
        end else begin
            n_tests++; if (vq_dist[0] !== INVALID) begin n_fail++; $display("FAIL ovr_dist: got %0h expected %0h", vq_dist[0], INVALID); end
            n_tests++; if (vq_oor[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_oor: got %b expected 1", vq_oor[0]); end
            n_tests++;
            if (vq_cyc[0] < exp_c - CLK_DIV || vq_cyc[0] > exp_c + CLK_DIV) begin
                n_fail++; $display("FAIL ovr_cycle: got %0d expected %0d +/- %0d", vq_cyc[0], exp_c, CLK_DIV);
            end
        end
        wait_trig(r2, f2, ok);
        n_tests++; if (r2 != r + 2 * PERIOD_CLK) begin n_fail++; $display("FAIL ovr_next_trig: got %0d expected %0d", r2, r + 2 * PERIOD_CLK); end
    endtask

    task automatic test_reset_mid_meas();
        int r, f;
        bit ok;
        wait_trig(r, f, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_trig: got none expected trigger"); end
        repeat (50 * CLK_DIV) step();
        echo = 1'b1;
        repeat (300 * CLK_DIV) step();
        clear_vq();
        reset = 1'b0;
        #1;
        n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL rst_mid_trig: got %b expected 0", trig); end
        n_tests++; if (distance_data !== 20'h0) begin n_fail++; $display("FAIL rst_mid_dist: got %0h expected 0", distance_data); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", data_valid); end
        n_tests++; if (out_of_range !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oor: got %b expected 0", out_of_range); end
        echo = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        wait_trig(r, f, ok);
        n_tests++; if (r != PERIOD_CLK) begin n_fail++; $display("FAIL rst_next_trig: got %0d expected %0d", r, PERIOD_CLK); end
        n_tests++; if (vq_cyc.size() != 0) begin n_fail++; $display("FAIL rst_stale_valid: got %0d pulses expected 0", vq_cyc.size()); end
    endtask

    task automatic test_glitch();
        int r, f;
        bit ok;
        wait_trig(r, f, ok);
        clear_vq();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL glitch_trig: got none expected trigger"); end
        repeat (50 * CLK_DIV) step();
        echo = 1'b1;
        #2;
        echo = 1'b0;
        wait_valid(1, ECHO_WAIT_US * CLK_DIV + 50);
        n_tests++;
        if (vq_cyc.size() == 0) begin
            n_fail++; $display("FAIL glitch_valid: got no pulse expected timeout");
        end else begin
            n_tests++; if (vq_cyc[0] != f + ECHO_WAIT_US * CLK_DIV) begin n_fail++; $display("FAIL glitch_cycle: got %0d expected %0d", vq_cyc[0], f + ECHO_WAIT_US * CLK_DIV); end
            n_tests++; if (vq_dist[0] !== INVALID) begin n_fail++; $display("FAIL glitch_dist: got %0h expected %0h", vq_dist[0], INVALID); end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_q[$];
        int          exp_c[$];
        int fc, len, d;
        bit ok;
        clear_vq();
        for (int k = 0; k < 3; k++) begin
            len = $urandom_range(1100, 30);
            d   = $urandom_range(200, 5);
            run_echo(d, len, 1'b0, fc, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_trig_%0d: got none expected trigger", k); end
            exp_q.push_back(exp_dist(len));
            exp_c.push_back(fc + 3);
            wait_valid(k + 1, 20);
        end
        repeat (20) step();
        n_tests++; if (vq_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", vq_cyc.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < vq_cyc.size()) begin
                n_tests++; if (vq_dist[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_dist_%0d: got %0d expected %0d", k, vq_dist[k], exp_q[k]); end
                n_tests++; if (vq_cyc[k] != exp_c[k]) begin n_fail++; $display("FAIL b2b_cycle_%0d: got %0d expected %0d", k, vq_cyc[k], exp_c[k]); end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        echo    = 1'b0;
        test_reset();
        test_echo_lengths();
        test_overrange_drain();
        test_reset_mid_meas();
        test_glitch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
